reg_writeback: RTL and testbench

REG_WRITEBACK -- requirements
Module: reg_writeback

---
 rtl/reg_writeback_if.sv | 15 +
 rtl/reg_writeback.sv | 152 +++++++++++++++
 tb/tb_reg_writeback.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_writeback_if.sv
// reg_writeback_if -- write-request handshake bundle for reg_writeback.
//   wb_valid : upstream request valid
//   wb_ready : request buffer can accept (transfer when both high at clk rise)
//   wb_rd    : destination register index
//   wb_data  : value to write
// master = request producer, slave = reg_writeback.
interface reg_writeback_if;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    modport master (output wb_valid, output wb_rd, output wb_data, input wb_ready);
    modport slave  (input wb_valid, input wb_rd, input wb_data, output wb_ready);
endinterface

// File: rtl/reg_writeback.sv
// reg_writeback -- buffers register write requests in a small FIFO and
// replays each one to the register file as a SETUP/STROBE/HOLD sequence, so
// address and data are stable one cycle either side of the RegWrite pulse.
//
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   wb (slave)     : write-request handshake (wb_valid/wb_ready/wb_rd/wb_data)
//   WriteRegister  : register-file write index (registered)
//   WriteData      : register-file write data (registered)
//   RegWrite       : register-file write strobe (registered)
//   busy           : FIFO non-empty or sequencer active
//   byp_rs/byp_hit/byp_data : forwarding lookup, only with WB_BYPASS_EN
//
// Parameters: FIFO_DEPTH (power of two, 2..8), DISCARD_R0 (drop writes to r0).
// Optional feature macro: WB_BYPASS_EN adds the forwarding lookup ports.
//
// state  | meaning
// IDLE   | nothing in flight, outputs hold last write
// SETUP  | head entry loaded onto WriteRegister/WriteData, strobe low
// STROBE | RegWrite high; head popped on leaving this state
// HOLD   | strobe low, address/data held one more cycle
module reg_writeback #(
    parameter int FIFO_DEPTH = 2,
    parameter bit DISCARD_R0 = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    reg_writeback_if.slave wb,
    output logic [4:0]  WriteRegister,
    output logic [31:0] WriteData,
    output logic        RegWrite,
    output logic        busy
`ifdef WB_BYPASS_EN
    ,
    input  logic [4:0]  byp_rs,
    output logic        byp_hit,
    output logic [31:0] byp_data
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_e;

    state_e state, nextState;

    logic [PTR_W:0]   wrPtr, rdPtr;
    logic [4:0]       memRd   [FIFO_DEPTH];
    logic [31:0]      memData [FIFO_DEPTH];
    logic             empty, full;
    logic             readyEn;
    logic             accept, push, pop;
    logic [PTR_W-1:0] headIdx;

    // Pointers carry one extra wrap bit so full and empty are distinct.
    assign empty   = (wrPtr == rdPtr);
    assign full    = (wrPtr[PTR_W] != rdPtr[PTR_W]) &&
                     (wrPtr[PTR_W-1:0] == rdPtr[PTR_W-1:0]);
    assign headIdx = rdPtr[PTR_W-1:0];

    // readyEn keeps wb_ready low during reset and for the first edge after it.
    assign wb.wb_ready = readyEn & ~full;
    assign accept      = wb.wb_valid & wb.wb_ready;
    assign push        = accept & ~(DISCARD_R0 && (wb.wb_rd == 5'd0));
    assign pop         = (state == STROBE);
    assign busy        = ~empty | (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            readyEn <= 1'b0;
        end else begin
            readyEn <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + 1'b1;
            if (pop)  rdPtr <= rdPtr + 1'b1;
        end
    end

    // Storage needs no reset: entries are only ever read between the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            memRd[wrPtr[PTR_W-1:0]]   <= wb.wb_rd;
            memData[wrPtr[PTR_W-1:0]] <= wb.wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (!empty) nextState = SETUP;
            SETUP:   nextState = STROBE;
            STROBE:  nextState = HOLD;
            HOLD:    nextState = empty ? IDLE : SETUP;
            default: nextState = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RegWrite      <= 1'b0;
            WriteRegister <= '0;
            WriteData     <= '0;
        end else begin
            RegWrite <= (nextState == STROBE);
            if (nextState == SETUP) begin
                WriteRegister <= memRd[headIdx];
                WriteData     <= memData[headIdx];
            end
        end
    end

`ifdef WB_BYPASS_EN
    logic [PTR_W:0]   count;
    logic [PTR_W-1:0] bypIdx;

    assign count = wrPtr - rdPtr;

    // The in-flight entry stays at the FIFO head until the STROBE edge, so a
    // scan of the live entries from oldest to youngest covers SETUP/STROBE
    // too; later matches overwrite earlier ones, leaving the youngest.
    always_comb begin
        byp_hit  = 1'b0;
        byp_data = '0;
        bypIdx   = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            bypIdx = headIdx + PTR_W'(i);
            if (((PTR_W+1)'(i) < count) && (byp_rs != 5'd0) &&
                (memRd[bypIdx] == byp_rs)) begin
                byp_hit  = 1'b1;
                byp_data = memData[bypIdx];
            end
        end
    end
`endif

endmodule

// File: tb/tb_reg_writeback.sv
module tb_reg_writeback;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  WriteRegister;
    logic [31:0] WriteData;
    logic        RegWrite;
    logic        busy;
`ifdef WB_BYPASS_EN
    logic [4:0]  byp_rs = 5'd0;
    logic        byp_hit;
    logic [31:0] byp_data;
`endif

    reg_writeback_if wbIf ();

    reg_writeback #(.FIFO_DEPTH(DEPTH), .DISCARD_R0(1'b1)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .wb(wbIf),
        .WriteRegister(WriteRegister),
        .WriteData(WriteData),
        .RegWrite(RegWrite),
        .busy(busy)
`ifdef WB_BYPASS_EN
        ,
        .byp_rs(byp_rs),
        .byp_hit(byp_hit),
        .byp_data(byp_data)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: each committed request has an accept edge and a strobe
    // cycle; strobe = max(accept + 2, previous strobe + 3). Everything else
    // (outputs, busy, ready) is derived from these times.
    typedef struct {
        int          acc;
        int          stb;
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    typedef struct {
        logic        v;
        logic [4:0]  rd;
        logic [31:0] d;
        logic        eRw;
        logic [4:0]  eWr;
        logic [31:0] eWd;
        logic        eBusy;
        logic        eRdy;
    } vec_t;

    ent_t ents[$];
    int   lastStb;
    int   cyc;
    int   tests = 0;
    int   fails = 0;
    logic prevRw = 1'b0;
    int   pulseCyc[$];
    logic [4:0] pulseRd[$];
    logic [31:0] pulseData[$];
    vec_t tbl[10];

    function automatic logic expRegWrite(int k);
        foreach (ents[i]) if (ents[i].stb == k) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [36:0] expWb(int k);
        logic [36:0] r = '0;
        foreach (ents[i]) if (ents[i].stb - 1 <= k) r = {ents[i].rd, ents[i].data};
        return r;
    endfunction

    function automatic logic expBusy(int k);
        foreach (ents[i]) if (ents[i].acc <= k && k <= ents[i].stb + 1) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic expReady(int k);
        int n = 0;
        if (k < 1) return 1'b0;
        foreach (ents[i]) if (ents[i].acc <= k && ents[i].stb >= k) n++;
        return (n < DEPTH);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    task automatic sample();
        logic [36:0] w;
        #1;
        w = expWb(cyc);
        chk("RegWrite", 32'(RegWrite), 32'(expRegWrite(cyc)));
        chk("WriteRegister", 32'(WriteRegister), 32'(w[36:32]));
        chk("WriteData", WriteData, w[31:0]);
        chk("busy", 32'(busy), 32'(expBusy(cyc)));
        chk("wb_ready", 32'(wbIf.wb_ready), 32'(expReady(cyc)));
        if (RegWrite && !prevRw) begin
            pulseCyc.push_back(cyc);
            pulseRd.push_back(WriteRegister);
            pulseData.push_back(WriteData);
        end
        prevRw = RegWrite;
    endtask

    task automatic drive(logic v, logic [4:0] rd, logic [31:0] data);
        ent_t e;
        wbIf.wb_valid = v;
        wbIf.wb_rd    = rd;
        wbIf.wb_data  = data;
        if (v && expReady(cyc) && rd != 5'd0) begin
            e.acc  = cyc + 1;
            e.stb  = (cyc + 3 > lastStb + 3) ? cyc + 3 : lastStb + 3;
            e.rd   = rd;
            e.data = data;
            lastStb = e.stb;
            ents.push_back(e);
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic doReset();
        wbIf.wb_valid = 1'b0;
        wbIf.wb_rd    = '0;
        wbIf.wb_data  = '0;
        rst_n = 1'b0;
        #1;
        chk("rst_RegWrite", 32'(RegWrite), 32'd0);
        chk("rst_WriteRegister", 32'(WriteRegister), 32'd0);
        chk("rst_WriteData", WriteData, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(wbIf.wb_ready), 32'd0);
        repeat (3) @(negedge clk);
        rst_n   = 1'b1;
        cyc     = 0;
        lastStb = -100;
        ents.delete();
    endtask

    initial begin
        int sent;
        int lowSeen;
        bit gotStrobe;

        tbl[0] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 1'b0};
        tbl[1] = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,        1'b0, 1'b1};
        tbl[2] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b1, 1'b1};
        tbl[3] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd5, 32'hDEADBEEF, 1'b1, 1'b1};
        tbl[4] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 1'b1};
        tbl[5] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd5, 32'hDEADBEEF, 1'b1, 1'b1};
        tbl[6] = '{1'b1, 5'd0, 32'h1234,     1'b0, 5'd5, 32'hDEADBEEF, 1'b0, 1'b1};
        tbl[7] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd5, 32'hDEADBEEF, 1'b0, 1'b1};
        tbl[8] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd5, 32'hDEADBEEF, 1'b0, 1'b1};
        tbl[9] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd5, 32'hDEADBEEF, 1'b0, 1'b1};

        @(negedge clk);
        doReset();

        // Single write to r5, then a discarded write to r0.
        for (int i = 0; i < 10; i++) begin
            sample();
            chk("vec_RegWrite", 32'(RegWrite), 32'(tbl[i].eRw));
            chk("vec_WriteRegister", 32'(WriteRegister), 32'(tbl[i].eWr));
            chk("vec_WriteData", WriteData, tbl[i].eWd);
            chk("vec_busy", 32'(busy), 32'(tbl[i].eBusy));
            chk("vec_ready", 32'(wbIf.wb_ready), 32'(tbl[i].eRdy));
            drive(tbl[i].v, tbl[i].rd, tbl[i].d);
        end

        // Three back-to-back requests into a depth-2 FIFO.
        pulseCyc.delete();
        pulseRd.delete();
        pulseData.delete();
        sent    = 0;
        lowSeen = 0;
        for (int i = 0; i < 30; i++) begin
            sample();
            if (sent < 3) begin
                if (!wbIf.wb_ready && cyc > 0) lowSeen++;
                if (expReady(cyc)) begin
                    drive(1'b1, 5'(sent + 1), 32'hA000_0000 + 32'(sent));
                    sent++;
                end else begin
                    drive(1'b1, 5'(sent + 1), 32'hA000_0000 + 32'(sent));
                end
            end else begin
                drive(1'b0, 5'd0, 32'h0);
            end
        end
        chk("b2b_pulse_count", 32'(pulseCyc.size()), 32'd3);
        chk("b2b_ready_low_seen", 32'(lowSeen > 0), 32'd1);
        if (pulseCyc.size() == 3) begin
            chk("b2b_spacing_1", 32'(pulseCyc[1] - pulseCyc[0]), 32'd3);
            chk("b2b_spacing_2", 32'(pulseCyc[2] - pulseCyc[1]), 32'd3);
            for (int i = 0; i < 3; i++) begin
                chk("b2b_order_rd", 32'(pulseRd[i]), 32'(i + 1));
                chk("b2b_order_data", pulseData[i], 32'hA000_0000 + 32'(i));
            end
        end

        // Reset while the strobe is high.
        doReset();
        sample();
        drive(1'b0, 5'd0, 32'h0);
        sample();
        drive(1'b1, 5'd9, 32'hCAFE_F00D);
        gotStrobe = 1'b0;
        for (int i = 0; i < 10; i++) begin
            sample();
            if (RegWrite) begin
                gotStrobe = 1'b1;
                break;
            end
            drive(1'b0, 5'd0, 32'h0);
        end
        chk("mid_strobe_reached", 32'(gotStrobe), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_RegWrite", 32'(RegWrite), 32'd0);
        chk("async_WriteData", WriteData, 32'd0);
        chk("async_busy", 32'(busy), 32'd0);
        chk("async_ready", 32'(wbIf.wb_ready), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n   = 1'b1;
        cyc     = 0;
        lastStb = -100;
        ents.delete();
        pulseCyc.delete();
        pulseRd.delete();
        pulseData.delete();
        for (int i = 0; i < 12; i++) begin
            sample();
            drive(1'b0, 5'd0, 32'h0);
        end
        chk("post_reset_pulses", 32'(pulseCyc.size()), 32'd0);

`ifdef WB_BYPASS_EN
        doReset();
        sample();
        drive(1'b0, 5'd0, 32'h0);
        sample();
        drive(1'b1, 5'd7, 32'h11);
        sample();
        drive(1'b1, 5'd7, 32'h22);
        byp_rs = 5'd7;
        #1;
        chk("byp_hit_r7", 32'(byp_hit), 32'd1);
        chk("byp_data_r7", byp_data, 32'h22);
        byp_rs = 5'd0;
        #1;
        chk("byp_hit_r0", 32'(byp_hit), 32'd0);
        for (int i = 0; i < 10; i++) begin
            sample();
            drive(1'b0, 5'd0, 32'h0);
        end
`endif

        // Randomized traffic against the timing model.
        doReset();
        for (int i = 0; i < 600; i++) begin
            sample();
            drive(($urandom_range(0, 99) < 55) ? 1'b1 : 1'b0,
                  5'($urandom_range(0, 31)), $urandom);
        end
        for (int i = 0; i < 20; i++) begin
            sample();
            drive(1'b0, 5'd0, 32'h0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
